// File: rtl/i2s_pkg.sv
// Shared I2S transmitter types and constants.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;
    localparam int I2S_SLOT_W = 32;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } i2s_stereo_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk into sclk and flags the clk cycle of each sclk edge.
module i2s_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;

    assign div_tc = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Strobes mark the cycle in which the sclk register is about to toggle.
    assign sclk_rise = div_tc & ~sclk;
    assign sclk_fall = div_tc & sclk;

endmodule

// File: rtl/i2s_stereo_tx.sv
// I2S master transmitter: one-entry stereo hold buffer, frame registers, sd/ws serialiser.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of sending silence.
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              sclk,
    output logic              ws,
    output logic              sd,
    output logic              underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int POS_W   = $clog2(FRAME_W);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_W - 1);
    localparam logic [POS_W-1:0] RIGHT_POS = POS_W'(SLOT_W);
    localparam logic [POS_W-1:0] WS_ON     = POS_W'(SLOT_W - 1);
    localparam logic [POS_W-1:0] WS_OFF    = POS_W'(FRAME_W - 2);

    logic              sclk_fall;
    logic              sclk_rise_unused;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_nxt;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] frm_l;
    logic [DATA_W-1:0] frm_r;
    logic [DATA_W-1:0] frm_l_nxt;
    logic [DATA_W-1:0] frm_r_nxt;
    logic              armed;
    logic              accept;
    logic              load;
    i2s_ch_e           ch_nxt;
    logic              sd_nxt;

    // MSB-first bit k of a sample; positions past the sample width shift out to zero padding.
    function automatic logic slot_bit(input logic [DATA_W-1:0] w, input logic [POS_W-1:0] k);
        logic [DATA_W-1:0] sh;
        sh = w << k;
        return sh[DATA_W-1];
    endfunction

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .sclk_rise (sclk_rise_unused),
        .sclk_fall (sclk_fall)
    );

    assign s_ready = ~hold_full;
    assign accept  = s_valid & s_ready;

    always_comb begin
        pos_nxt   = (pos == POS_LAST) ? '0 : pos + 1'b1;
        load      = sclk_fall & (pos == POS_LAST);
        frm_l_nxt = frm_l;
        frm_r_nxt = frm_r;
        if (load) begin
            if (hold_full) begin
                frm_l_nxt = hold_l;
                frm_r_nxt = hold_r;
            end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                frm_l_nxt = frm_l;
                frm_r_nxt = frm_r;
`else
                frm_l_nxt = '0;
                frm_r_nxt = '0;
`endif
            end
        end
        // ws switches one bit ahead of each slot's MSB.
        ch_nxt = ((pos_nxt >= WS_ON) && (pos_nxt <= WS_OFF)) ? CH_RIGHT : CH_LEFT;
        if (pos_nxt >= RIGHT_POS) begin
            sd_nxt = slot_bit(frm_r_nxt, pos_nxt - RIGHT_POS);
        end else begin
            sd_nxt = slot_bit(frm_l_nxt, pos_nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos       <= POS_LAST;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            frm_l     <= '0;
            frm_r     <= '0;
            armed     <= 1'b0;
            ws        <= 1'b0;
            sd        <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= load & ~hold_full & armed;
            if (sclk_fall) begin
                pos   <= pos_nxt;
                ws    <= ch_nxt;
                sd    <= sd_nxt;
                frm_l <= frm_l_nxt;
                frm_r <= frm_r_nxt;
            end
            // A pair accepted during a load waits in the hold for the next frame.
            if (accept) begin
                hold_l    <= s_left;
                hold_r    <= s_right;
                hold_full <= 1'b1;
                armed     <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Randomised self-checking bench for i2s_stereo_tx with a frame-level reference model.
module tb_i2s_stereo_tx;

    localparam int DATA_W  = 24;
    localparam int SLOT_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int FRAME_B = 2 * SLOT_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        s_ready, sclk, ws, sd, underrun;

    int vectors = 0;
    int miscompares = 0;
    int nprint = 0;
    int cyc = 0;
    int rel_cyc = 0;
    bit chk_en = 1'b0;
    int und_cnt = 0;
    int sd_ones = 0;
    logic [63:0] cap[$];

    // reference model state
    int          t;
    logic [47:0] mq[$];
    logic [23:0] m_l, m_r;
    bit          m_armed;
    logic        e_sclk, e_ws, e_sd, e_und, e_rdy;

    i2s_stereo_tx #(
        .DATA_W  (DATA_W),
        .SLOT_W  (SLOT_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .sclk     (sclk),
        .ws       (ws),
        .sd       (sd),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
            end
        end
    endtask

    function automatic logic frame_bit(input logic [23:0] l, input logic [23:0] r, input int p);
        int k;
        if (p < SLOT_W) begin
            k = p;
            return (k < DATA_W) ? l[23-k] : 1'b0;
        end
        k = p - SLOT_W;
        return (k < DATA_W) ? r[23-k] : 1'b0;
    endfunction

    // Model: time since reset determines sclk; each fall advances the bit position,
    // and at each frame start the oldest queued pair becomes the frame.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            t = 0; mq.delete(); m_l = '0; m_r = '0; m_armed = 1'b0;
            e_sclk = 1'b0; e_ws = 1'b0; e_sd = 1'b0; e_und = 1'b0; e_rdy = 1'b1;
        end else begin
            automatic bit acc = s_valid && e_rdy;
            automatic logic [47:0] pr;
            t++;
            e_und  = 1'b0;
            e_sclk = ((t / CLK_DIV) % 2) == 1;
            if (t % (2 * CLK_DIV) == 0) begin
                automatic int p = (t / (2 * CLK_DIV) - 1) % FRAME_B;
                if (p == 0) begin
                    if (mq.size() > 0) begin
                        pr = mq.pop_front();
                        m_l = pr[47:24];
                        m_r = pr[23:0];
                    end else begin
                        if (m_armed) e_und = 1'b1;
`ifndef I2S_TX_UNDERRUN_HOLD_EN
                        m_l = '0;
                        m_r = '0;
`endif
                    end
                end
                e_ws = (p >= SLOT_W - 1) && (p <= FRAME_B - 2);
                e_sd = frame_bit(m_l, m_r, p);
            end
            if (acc) begin
                mq.push_back({s_left, s_right});
                m_armed = 1'b1;
            end
            e_rdy = (mq.size() == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("sclk", 64'(sclk), 64'(e_sclk));
            check("ws", 64'(ws), 64'(e_ws));
            check("sd", 64'(sd), 64'(e_sd));
            check("underrun", 64'(underrun), 64'(e_und));
            check("s_ready", 64'(s_ready), 64'(e_rdy));
        end
    end

    // Codec-side receiver: shifts sd on each sclk rise, frames close where ws drops.
    initial begin
        automatic logic sclk_prev = 1'b0;
        automatic logic ws_at_rise = 1'b0;
        automatic logic [63:0] sr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sclk_prev = 1'b0; ws_at_rise = 1'b0; sr = '0;
            end else begin
                if (underrun === 1'b1) und_cnt++;
                if (sd === 1'b1) sd_ones++;
                if (sclk && !sclk_prev) begin
                    sr = {sr[62:0], sd};
                    if (ws_at_rise && !ws) cap.push_back(sr);
                    ws_at_rise = ws;
                end
                sclk_prev = sclk;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        cap.delete();
        und_cnt = 0;
        sd_ones = 0;
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - rel_cyc < n) @(negedge clk);
    endtask

    task automatic wait_lvl(input bit use_ws, input logic lvl, output int tstamp);
        int n = 0;
        while (((use_ws ? ws : sclk) !== lvl) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("wait_timeout", 64'(n), 64'(0));
        tstamp = cyc;
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        while (s_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("send_timeout", 64'(n), 64'(0));
        @(negedge clk);
    endtask

    function automatic logic [63:0] frm(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    initial begin
        int t1, t2, t3, n;
        logic [23:0] p1l, p1r, p2l, p2r, rl, rr;
        logic [47:0] sent[$];

        // reset values
        repeat (3) @(negedge clk);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_ws", 64'(ws), 64'd0);
        check("rst_sd", 64'(sd), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        rel_cyc = cyc;

        // idle: clock timing and silence without underrun
        wait_lvl(1'b0, 1'b1, t1);
        check("first_rise", 64'(t1 - rel_cyc), 64'd2);
        wait_lvl(1'b0, 1'b0, t2);
        wait_lvl(1'b0, 1'b1, t3);
        check("sclk_period", 64'(t3 - t1), 64'd4);
        wait_lvl(1'b1, 1'b1, t1);
        wait_lvl(1'b1, 1'b0, t2);
        wait_lvl(1'b1, 1'b1, t3);
        check("ws_high", 64'(t2 - t1), 64'd128);
        check("ws_period", 64'(t3 - t1), 64'd256);
        wait_rel(5 * 256 + 8);
        check("idle_underruns", 64'(und_cnt), 64'd0);
        check("idle_sd_ones", 64'(sd_ones), 64'd0);

        // single known pair
        do_reset();
        send(24'hA50F3C, 24'h800001);
        s_valid = 1'b0;
        wait_rel(300);
        check("single_frames", 64'(cap.size() >= 1), 64'd1);
        if (cap.size() >= 1) check("single_frame", cap[0], 64'hA50F3C00_80000100);

        // two pairs then stall
        p1l = 24'($urandom); p1r = 24'($urandom);
        p2l = 24'($urandom); p2r = 24'($urandom);
        do_reset();
        send(p1l, p1r);
        send(p2l, p2r);
        s_valid = 1'b0;
        wait_rel(1100);
        check("stall_underruns", 64'(und_cnt), 64'd3);
        check("stall_frames", 64'(cap.size() >= 3), 64'd1);
        if (cap.size() >= 3) begin
            check("stall_f0", cap[0], frm(p1l, p1r));
            check("stall_f1", cap[1], frm(p2l, p2r));
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            check("stall_f2", cap[2], frm(p2l, p2r));
`else
            check("stall_f2", cap[2], 64'd0);
`endif
        end

        // reset in the middle of the right slot
        do_reset();
        send(24'h123456, 24'h7FFFFF);
        s_valid = 1'b0;
        wait_rel(170);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sclk", 64'(sclk), 64'd0);
        check("mid_rst_ws", 64'(ws), 64'd0);
        check("mid_rst_sd", 64'(sd), 64'd0);
        check("mid_rst_ready", 64'(s_ready), 64'd1);
        check("mid_rst_underrun", 64'(underrun), 64'd0);
        repeat (3) @(negedge clk);
        cap.delete();
        rst = 1'b0;
        rel_cyc = cyc;
        wait_rel(5);
        check("post_rst_ws", 64'(ws), 64'd0);
        check("post_rst_sd", 64'(sd), 64'd0);
        wait_rel(300);
        check("post_rst_frame", (cap.size() >= 1) ? cap[0] : 64'hDEAD, 64'd0);

        // back-to-back random stream
        do_reset();
        for (int k = 0; k < 100; k++) begin
            rl = 24'($urandom); rr = 24'($urandom);
            send(rl, rr);
            sent.push_back({rl, rr});
            if (k == 0) check("stream_ready_low", 64'(s_ready), 64'd0);
        end
        check("stream_underruns", 64'(und_cnt), 64'd0);
        s_valid = 1'b0;
        n = 0;
        while (cap.size() < 100 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("stream_count", 64'(cap.size() >= 100), 64'd1);
        for (int k = 0; k < 100 && k < cap.size(); k++)
            check("stream_frame", cap[k], frm(sent[k][47:24], sent[k][23:0]));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
